// File: rtl/tx_scheduler_if.sv
// Bundle of requester-side and encoder-side signals around the transmit scheduler.
// The scheduler uses the slave modport; the environment uses the master modport.
`ifndef FRAME_SIZE
`define FRAME_SIZE 16
`endif

interface tx_scheduler_if #(
  parameter int N_REQ      = 4,
  parameter int FRAME_SIZE = `FRAME_SIZE
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*FRAME_SIZE-1:0] req_data;
  logic [N_REQ-1:0]            ack;
  logic [N_REQ-1:0]            err;
  logic                        busy;
  logic [FRAME_SIZE-1:0]       enc_data;
  logic                        enc_start;
  logic                        enc_irq;

  modport master (
    output req, req_data, enc_irq,
    input  ack, err, busy, enc_data, enc_start
  );

  modport slave (
    input  req, req_data, enc_irq,
    output ack, err, busy, enc_data, enc_start
  );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one frame encoder between N_REQ requesters,
// with a per-frame timeout and an enforced idle gap between frames.
`ifndef FRAME_SIZE
`define FRAME_SIZE 16
`endif

module tx_scheduler #(
  parameter int N_REQ      = 4,
  parameter int FRAME_SIZE = `FRAME_SIZE,
  parameter int TIMEOUT    = 1024,
  parameter int GAP        = 2
) (
  input  logic          clock,
  input  logic          reset,
  tx_scheduler_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [FRAME_SIZE-1:0] data_q, data_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [N_REQ-1:0]      err_q, err_d;

  logic [PTR_W:0]        scan_idx;
  logic [PTR_W:0]        pick_inc;
  logic [PTR_W-1:0]      pick;
  logic [PTR_W-1:0]      pick_next;

  // First requester at or after ptr, wrapping; scanning downward lets the
  // lowest rotated offset win without an extra found flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    scan_idx  = '0;
    pick      = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(N_REQ))
        scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
      if (bus.req[scan_idx[PTR_W-1:0]])
        pick = scan_idx[PTR_W-1:0];
    end
    pick_inc  = {1'b0, pick} + (PTR_W+1)'(1);
    pick_next = (pick_inc == (PTR_W+1)'(N_REQ)) ? '0 : pick_inc[PTR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    data_d  = data_q;
    start_d = start_q;
    ack_d   = '0;
    err_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          grant_d = pick;
          ptr_d   = pick_next;
          data_d  = bus.req_data[pick*FRAME_SIZE +: FRAME_SIZE];
          start_d = 1'b1;
          timer_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Completion takes precedence over a coincident timeout.
        if (bus.enc_irq) begin
          ack_d[grant_q] = 1'b1;
          start_d        = 1'b0;
          gap_d          = '0;
          state_d        = S_GAP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d[grant_q] = 1'b1;
          start_d        = 1'b0;
          gap_d          = '0;
          state_d        = S_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        // The ack/err cycle is the first gap cycle.
        start_d = 1'b0;
        if (gap_q == GAP_W'(GAP - 1))
          state_d = S_IDLE;
        else
          gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.enc_data  = data_q;
  assign bus.enc_start = start_q;
  assign bus.busy      = busy_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Round-robin transmit scheduler that shares the single optical `encoder` between `N_REQ` requesters. It grants one requester at a time, latches that requester's frame, and drives the encoder's `data`/`start` handshake until the encoder's `irq` reports completion or a timeout expires. It then reports completion or timeout back to the granted requester and enforces an inter-frame idle gap on the LED link. It sits between the host-side frame sources and the `encoder`, whose `led` output feeds the `decoder` on the far side.

## Interface
- `N_REQ`, default 4: number of requesters, at least 2.
- `FRAME_SIZE`, default `` `FRAME_SIZE `` (16): frame width in bits.
- `TIMEOUT`, default 1024: maximum number of cycles `enc_start` is held high waiting for `enc_irq`.
- `GAP`, default 2: number of cycles spent in the gap state after each frame.
- `clock` in 1: the single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_REQ: level request, one bit per requester.
- `req_data` in N_REQ*FRAME_SIZE: requester i's frame is `req_data[i*FRAME_SIZE +: FRAME_SIZE]`.
- `ack` out N_REQ: one-cycle, one-hot pulse when the granted frame completes.
- `err` out N_REQ: one-cycle, one-hot pulse when the granted frame times out.
- `busy` out 1: high whenever state is not IDLE.
- `enc_data` out FRAME_SIZE: connects to encoder `data`.
- `enc_start` out 1: connects to encoder `start`.
- `enc_irq` in 1: connects to encoder `irq`.

## Operation
- All outputs are registered.
- Reset values: `enc_start`=0, `enc_data`=0, `ack`=0, `err`=0, `busy`=0. State resets to IDLE and the priority pointer `ptr` resets to 0.
- **IDLE**
  - If `req` is nonzero, pick the grant `g` as the first set bit scanning `ptr`, `ptr+1`, … modulo N_REQ.
  - Latch `enc_data` from requester g's slice, register `g`, set `ptr` to (g+1) mod N_REQ.
  - Set `enc_start`=1, clear the timer, go to SEND.
- **SEND**
  - `enc_start` and `enc_data` are held constant.
  - If `enc_irq`=1: pulse `ack[g]`, drop `enc_start`, go to GAP.
  - Else if timer == TIMEOUT-1: pulse `err[g]`, drop `enc_start`, go to GAP.
  - Else increment the timer.
- **GAP**
  - `enc_start`=0; `enc_irq` is ignored.
  - Stays GAP cycles, counting the ack/err cycle as the first, then goes to IDLE.
- Requester rules:
  - A requester holds `req` until it sees its `ack` or `err`.
  - Its data is sampled only at grant; later changes are ignored.
  - If `req` is still high after the ack, it is re-arbitrated normally.
- A deasserted `req` is never granted. A request withdrawn after grant does not abort the frame; its ack/err is still pulsed.
- If `enc_irq` and the timeout condition occur in the same cycle, ack wins and no err is pulsed.
- Reset mid-frame:
  - Next edge: all outputs 0, state IDLE, `ptr` 0.
  - No ack or err is issued for the aborted frame.
- `ack | err` is zero or one-hot every cycle. `ack` and `err` are never both high.
- The timer is $clog2(TIMEOUT) bits wide and never wraps, because it is cleared on entering SEND.

## Timing
- Request `req` sampled high in IDLE at edge k → `enc_start`=1, `enc_data` valid, `busy`=1 from edge k+1.
- `enc_irq` sampled high at edge m in SEND → from edge m+1: `ack[g]`=1 for one cycle, `enc_start`=0.
- The scheduler is in GAP for GAP cycles, then IDLE. The earliest next `enc_start` rise is edge m+GAP+2, so `enc_start` stays low at least GAP+1 cycles between frames.
- Timeout case: `enc_start` is high for exactly TIMEOUT cycles, then `err[g]` pulses on the following cycle.
- `busy` falls on the edge that enters IDLE.
- With all requesters asserted continuously, each is served once per N_REQ frames (no starvation).

## Test plan
- **Single request, real encoder and decoder in loopback.** Drive `req`=0001 with data0=16'hF4B6 → `enc_data`=F4B6 one cycle later. Decoder `data`=F4B6 with decoder `irq`. `ack`=0001 for exactly one cycle, `err`=0, exactly one `enc_start` rising edge.
- **All four requesters together.** Drive `req`=1111 with data 16'h1111/2222/3333/4444, each dropped after its ack → frames in order 0,1,2,3. Each ack pulses once. `enc_start` stays low at least GAP+1 cycles between frames.
- **Fairness.** Hold req0 permanently; assert req2 during frame 0 → the next grant is 2, then 0. Req0 is granted again only after 2.
- **Timeout.** Use a stub encoder with `irq` tied 0 and TIMEOUT=8, `req`=0010 → `enc_start` high exactly 8 cycles, then `err`=0010 for one cycle and no ack. A following `req`=0100 is served normally.
- **Same-cycle irq and timeout.** Stub raises `irq` exactly at timer==TIMEOUT-1 → `ack` pulses, `err` stays 0.
- **Data change and reset.**
  - Changing `req_data` after grant leaves `enc_data` unchanged.
  - Assert `reset` mid-SEND: all outputs are 0 on the next edge, with no ack/err.
  - After reset is released with `req`=0011, requester 0 is granted first.
